// File: rtl/tob_pkg.sv
// Shared definitions for the stacking-game drawing path.
// Screen geometry, colour codes, FSM encoding and clip helper.
package tob_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int DXW = 6;
  localparam int DYW = 5;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_BG    = COL_BLACK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_e;

  function automatic logic on_screen(
    input logic [8:0] px,
    input logic [7:0] py,
    input int         sw,
    input int         sh
  );
    return (32'(px) < sw) && (32'(py) < sh);
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major dx/dy walker over a BLOCK_W x BLOCK_H rectangle.
// Exposes next-state offsets so the caller can register pixels.
module rect_scanner
  import tob_pkg::*;
#(
  parameter int BLOCK_W = 16,
  parameter int BLOCK_H = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic           adv_i,
  output logic [DXW-1:0] dx_nxt_o,
  output logic [DYW-1:0] dy_nxt_o,
  output logic           last_o
);

  localparam logic [DXW-1:0] DX_MAX = DXW'(BLOCK_W - 1);
  localparam logic [DYW-1:0] DY_MAX = DYW'(BLOCK_H - 1);

  logic [DXW-1:0] dx_q, dx_d;
  logic [DYW-1:0] dy_q, dy_d;

  // next offset: restart at origin or step inner dx then outer dy
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (start_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (adv_i) begin
      if (dx_q == DX_MAX) begin
        dx_d = '0;
        dy_d = dy_q + DYW'(1);
      end else begin
        dx_d = dx_q + DXW'(1);
      end
    end
  end

  // offset registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx_nxt_o = dx_d;
  assign dy_nxt_o = dy_d;
  assign last_o   = (dx_q == DX_MAX) && (dy_q == DY_MAX);

endmodule

// File: rtl/block_renderer.sv
// Rasterises the game block into the VGA plot port.
// Optional erase of the previous block, one pixel per cycle.
module block_renderer #(
  parameter int         BLOCK_W   = 16,
  parameter int         BLOCK_H   = 4,
  parameter int         SCREEN_W  = tob_pkg::SCREEN_W,
  parameter int         SCREEN_H  = tob_pkg::SCREEN_H,
  parameter logic [2:0] BG_COLOUR = tob_pkg::COL_BG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic       erase_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot
);

  import tob_pkg::*;

  state_e state_q;

  logic [7:0] cap_x_q, prev_x_q, pend_x_q;
  logic [6:0] cap_y_q, prev_y_q, pend_y_q;
  logic [2:0] cap_col_q, pend_col_q;
  logic       pend_er_q, pend_valid_q, prev_valid_q;

  logic       busy_q, done_q, plot_q;
  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] vga_col_q;

  logic           scan_start, scan_adv, last;
  logic [DXW-1:0] dx_nxt;
  logic [DYW-1:0] dy_nxt;

  logic       in_idle, in_done, in_erase, scanning;
  logic       use_req, op_go, op_er, op_erase;
  logic       src_prev_v;
  logic [7:0] op_x, src_prev_x, base_x;
  logic [6:0] op_y, src_prev_y, base_y;
  logic [2:0] op_col, base_col;
  logic       emit;
  logic [8:0] px;
  logic [7:0] py;

  rect_scanner #(
    .BLOCK_W (BLOCK_W),
    .BLOCK_H (BLOCK_H)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .start_i  (scan_start),
    .adv_i    (scan_adv),
    .dx_nxt_o (dx_nxt),
    .dy_nxt_o (dy_nxt),
    .last_o   (last)
  );

  // op selection, next pixel source and clip geometry
  always_comb begin
    in_idle  = (state_q == S_IDLE);
    in_done  = (state_q == S_DONE);
    in_erase = (state_q == S_ERASE);
    scanning = in_erase || (state_q == S_DRAW);

    use_req = in_idle || req;
    op_x    = use_req ? x_in      : pend_x_q;
    op_y    = use_req ? y_in      : pend_y_q;
    op_col  = use_req ? colour_in : pend_col_q;
    op_er   = use_req ? erase_en  : pend_er_q;
    op_go   = (in_idle && req) ||
              (in_done && (req || pend_valid_q));

    // in DONE the block just drawn becomes the one to erase
    src_prev_x = in_done ? cap_x_q : prev_x_q;
    src_prev_y = in_done ? cap_y_q : prev_y_q;
    src_prev_v = in_done || prev_valid_q;
    op_erase   = op_er && src_prev_v;

    scan_adv   = scanning && !last;
    scan_start = op_go || (in_erase && last);
    emit       = scan_start || scan_adv;

    base_x   = cap_x_q;
    base_y   = cap_y_q;
    base_col = cap_col_q;
    unique case (1'b1)
      op_go: begin
        base_x   = op_erase ? src_prev_x : op_x;
        base_y   = op_erase ? src_prev_y : op_y;
        base_col = op_erase ? BG_COLOUR  : op_col;
      end
      (in_erase && !last): begin
        base_x   = prev_x_q;
        base_y   = prev_y_q;
        base_col = BG_COLOUR;
      end
      default: ;
    endcase

    px = {1'b0, base_x} + 9'(dx_nxt);
    py = {1'b0, base_y} + 8'(dy_nxt);
  end

  // control FSM with registered pixel and handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_col_q    <= '0;
      prev_valid_q <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_er_q    <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_col_q   <= '0;
      cap_x_q      <= '0;
      cap_y_q      <= '0;
      cap_col_q    <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
    end else begin
      plot_q <= emit && on_screen(px, py, SCREEN_W, SCREEN_H);
      if (emit) begin
        vga_x_q   <= px[7:0];
        vga_y_q   <= py[6:0];
        vga_col_q <= base_col;
      end

      if (req && scanning) begin
        pend_valid_q <= 1'b1;
        pend_x_q     <= x_in;
        pend_y_q     <= y_in;
        pend_col_q   <= colour_in;
        pend_er_q    <= erase_en;
      end

      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (op_go) begin
            cap_x_q   <= op_x;
            cap_y_q   <= op_y;
            cap_col_q <= op_col;
            busy_q    <= 1'b1;
            state_q   <= op_erase ? S_ERASE : S_DRAW;
          end
        end
        S_ERASE: begin
          if (last) state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (last) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q       <= 1'b0;
          prev_x_q     <= cap_x_q;
          prev_y_q     <= cap_y_q;
          prev_valid_q <= 1'b1;
          if (op_go) begin
            cap_x_q      <= op_x;
            cap_y_q      <= op_y;
            cap_col_q    <= op_col;
            pend_valid_q <= 1'b0;
            state_q      <= op_erase ? S_ERASE : S_DRAW;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_col_q;

endmodule
